// File: rtl/c3lib_cdc_hs_pkg.sv
// Shared definitions for the c3lib 4-phase req/ack CDC handshake (source, destination and bench).
package c3lib_cdc_hs_pkg;

  localparam int unsigned HS_STATE_W = 2;

  typedef enum logic [HS_STATE_W-1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    ACK_DROP = 2'd2
  } hs_state_e;

endpackage

// File: rtl/c3lib_sync2_reset_ulvt_gate.sv
// Two-flop synchronizer for a single bit; both stages are cleared by the async reset.
module c3lib_sync2_reset_ulvt_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic data_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      data_out <= 1'b0;
    end else begin
      meta     <= data_in;
      data_out <= meta;
    end
  end

endmodule

// File: rtl/c3lib_cdc_hs_src.sv
// Source side of a 4-phase req/ack CDC handshake: holds one word on data_out while req_out is high.
// Optional ack timeout is built in when C3LIB_CDC_HS_TIMEOUT_EN is defined.
module c3lib_cdc_hs_src
  import c3lib_cdc_hs_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_vld,
  output logic             data_in_rdy,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             xfer_done,
  output logic             err_timeout
);

  hs_state_e        state;
  logic [WIDTH-1:0] data_q;
  logic             req_q;
  logic             rdy_q;
  logic             done_q;
  logic [1:0]       warm;
  logic             ack_s;
  logic             timeout_fire;

  c3lib_sync2_reset_ulvt_gate u_ack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (ack_in),
    .data_out (ack_s)
  );

`ifdef C3LIB_CDC_HS_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] tcnt;
  logic                 err_q;

  // Fires on the edge where the counter would reach all-ones while still waiting on ack.
  assign timeout_fire = ((state == REQ && !ack_s) || (state == ACK_DROP && ack_s)) &&
                        (tcnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE || (state == REQ && ack_s)) tcnt <= '0;
      else if (tcnt != '1)                          tcnt <= tcnt + TIMEOUT_W'(1);
      if (timeout_fire) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^32'(TIMEOUT_W);
  assign timeout_fire = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // Handshake FSM. rdy waits for the synchronizer to fill after reset so a stale ack is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      req_q  <= 1'b0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      warm   <= 2'b00;
    end else begin
      warm   <= {warm[0], 1'b1};
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_in_vld && rdy_q) begin
            data_q <= data_in;
            req_q  <= 1'b1;
            state  <= REQ;
          end else begin
            rdy_q <= warm[1] && !ack_s;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q <= 1'b0;
            state <= ACK_DROP;
          end else if (timeout_fire) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        ACK_DROP: begin
          if (!ack_s) begin
            state  <= IDLE;
            done_q <= 1'b1;
            rdy_q  <= 1'b1;
          end else if (timeout_fire) begin
            state <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign req_out     = req_q;
  assign data_in_rdy = rdy_q;
  assign xfer_done   = done_q;

endmodule

// File: tb/tb_c3lib_cdc_hs_src.sv
// Self-checking bench for c3lib_cdc_hs_src: vector table, reset/stale-ack/timeout sequences, random scoreboard.
module tb_c3lib_cdc_hs_src;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned TO_W   = 4;
  localparam int unsigned NWORDS = 1000;
  localparam int unsigned BUDGET = 300;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             data_in_vld;
  logic             data_in_rdy;
  logic [WIDTH-1:0] data_out;
  logic             req_out;
  logic             ack_in;
  logic             xfer_done;
  logic             err_timeout;

  int tests;
  int fails;

  c3lib_cdc_hs_src #(.WIDTH(WIDTH), .TIMEOUT_W(TO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_in_vld (data_in_vld),
    .data_in_rdy (data_in_rdy),
    .data_out    (data_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .xfer_done   (xfer_done),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] din;
    logic             ack;
    logic             rdy;
    logic             req;
    logic [WIDTH-1:0] dout;
    logic             done;
  } vec_t;

  localparam int unsigned NVEC = 18;
  vec_t vecs [NVEC];

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] prev_data;
  logic             prev_req;
  int               stab_err;
  int               done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stability of data_out while req_out is held, and xfer_done pulse count.
  always @(negedge clk) begin
    if (rst_n && prev_req && req_out && data_out !== prev_data) stab_err++;
    if (rst_n && xfer_done) done_cnt++;
    prev_req  <= req_out;
    prev_data <= data_out;
  end

  task automatic do_reset(input logic ack_level);
    @(negedge clk);
    rst_n = 1'b0; data_in_vld = 1'b0; data_in = '0; ack_in = ack_level;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rdy(input string name);
    int n;
    n = 0;
    while (!data_in_rdy && n < BUDGET) begin @(negedge clk); n++; end
    chk(name, 32'(data_in_rdy), 32'd1);
  endtask

  initial begin
    int n_hi;
    int lat;
    logic seen_done;
    tests = 0; fails = 0; stab_err = 0; done_cnt = 0;
    prev_req = 1'b0; prev_data = '0;
    rst_n = 1'b0; data_in = '0; data_in_vld = 1'b0; ack_in = 1'b0;

    //                 vld   din    ack   rdy   req   dout   done
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[5]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[10] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("rst_rdy",  32'(data_in_rdy), 32'd0);
    chk("rst_req",  32'(req_out),     32'd0);
    chk("rst_data", 32'(data_out),    32'd0);
    chk("rst_done", 32'(xfer_done),   32'd0);
    chk("rst_err",  32'(err_timeout), 32'd0);
    rst_n = 1'b1;

    // Single transfer and back-to-back word straight after xfer_done.
    for (int i = 0; i < int'(NVEC); i++) begin
      data_in_vld = vecs[i].vld;
      data_in     = vecs[i].din;
      ack_in      = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i),  32'(data_in_rdy), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_req", i),  32'(req_out),     32'(vecs[i].req));
      chk($sformatf("vec%0d_data", i), 32'(data_out),    32'(vecs[i].dout));
      chk($sformatf("vec%0d_done", i), 32'(xfer_done),   32'(vecs[i].done));
    end

    // Ack stuck low: timeout build aborts after 15 cycles in REQ, default build waits forever.
    data_in = 8'h77; data_in_vld = 1'b1;
    @(negedge clk);
    data_in_vld = 1'b0;
    n_hi = 0; seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_out) n_hi++;
      if (xfer_done) seen_done = 1'b1;
      @(negedge clk);
    end
`ifdef C3LIB_CDC_HS_TIMEOUT_EN
    chk("to_req_cycles", 32'(n_hi),        32'd15);
    chk("to_err",        32'(err_timeout), 32'd1);
    chk("to_req_end",    32'(req_out),     32'd0);
`else
    chk("to_req_cycles", 32'(n_hi),        32'd40);
    chk("to_err",        32'(err_timeout), 32'd0);
    chk("to_req_end",    32'(req_out),     32'd1);
`endif
    chk("to_no_done", 32'(seen_done), 32'd0);
    chk("to_data",    32'(data_out),  32'h77);

    // Reset asserted mid-REQ clears outputs asynchronously.
    do_reset(1'b0);
    wait_rdy("mr_rdy");
    data_in = 8'hC3; data_in_vld = 1'b1;
    @(negedge clk);
    data_in_vld = 1'b0;
    chk("mr_req_before",  32'(req_out),  32'd1);
    chk("mr_data_before", 32'(data_out), 32'hC3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req",  32'(req_out),     32'd0);
    chk("mr_data", 32'(data_out),    32'd0);
    chk("mr_done", 32'(xfer_done),   32'd0);
    chk("mr_err",  32'(err_timeout), 32'd0);

    // Stale ack held through reset release: no rdy/req until ack drops.
    do_reset(1'b1);
    data_in = 8'h99; data_in_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stale%0d_rdy", i), 32'(data_in_rdy), 32'd0);
      chk($sformatf("stale%0d_req", i), 32'(req_out),     32'd0);
    end
    ack_in = 1'b0;
    lat = 0;
    while (!data_in_rdy && lat < 20) begin @(negedge clk); lat++; end
    chk("stale_rdy_latency", 32'(lat), 32'd3);
    @(negedge clk);
    data_in_vld = 1'b0;
    chk("stale_req",  32'(req_out),  32'd1);
    chk("stale_data", 32'(data_out), 32'h99);

    // Random ack delays against a destination model and in-order scoreboard.
    do_reset(1'b0);
    stab_err = 0; done_cnt = 0;
    @(negedge clk);
    fork
      begin : src
        for (int w = 0; w < int'(NWORDS); w++) begin
          int n;
          logic [WIDTH-1:0] word;
          word = WIDTH'($urandom);
          data_in = word; data_in_vld = 1'b1;
          n = 0;
          while (!data_in_rdy && n < int'(BUDGET)) begin @(negedge clk); n++; end
          if (!data_in_rdy) begin chk("src_wait", 32'd0, 32'd1); break; end
          exp_q.push_back(word);
          @(negedge clk);
          data_in_vld = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        data_in_vld = 1'b0;
      end
      begin : dst
        for (int w = 0; w < int'(NWORDS); w++) begin
          int n;
          logic [WIDTH-1:0] got;
          n = 0;
          while (!req_out && n < int'(BUDGET)) begin @(negedge clk); n++; end
          if (!req_out) begin chk("dst_req_rise", 32'd0, 32'd1); break; end
          repeat ($urandom_range(0, 20)) @(negedge clk);
          got = data_out;
          ack_in = 1'b1;
          n = 0;
          while (req_out && n < int'(BUDGET)) begin @(negedge clk); n++; end
          if (req_out) begin chk("dst_req_fall", 32'd1, 32'd0); break; end
          repeat ($urandom_range(0, 20)) @(negedge clk);
          ack_in = 1'b0;
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
          end else begin
            chk($sformatf("sb_word%0d", w), 32'(got), 32'(exp_q.pop_front()));
          end
        end
      end
    join
    repeat (10) @(negedge clk);
    chk("sb_done_count", 32'(done_cnt),     32'(NWORDS));
    chk("sb_leftover",   32'(exp_q.size()), 32'd0);
    chk("sb_stability",  32'(stab_err),     32'd0);
    chk("sb_err",        32'(err_timeout),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
